// File: rtl/px_mem_pkg.sv
// Shared types and helpers for the pixel frame memory and its arbiter.
package px_mem_pkg;

    // Controller states; the encoding is fixed so the FSM can use plain constants.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_GNT   = 2'd1,
        WR_CMD   = 2'd2,
        WR_BURST = 2'd3
    } px_state_e;

    // Index width for n items, never below one bit so single-client builds still elaborate.
    function automatic int px_clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/px_mem_mp_if.sv
// Bus bundle between the frame memory and its clients (one burst writer, N_RD readers).
interface px_mem_mp_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int N_RD    = 2,
    parameter int BURST_W = 4
);
    logic                   wr_req;
    logic                   wr_grant;
    logic [ADDR_W-1:0]      wr_addr;
    logic [BURST_W-1:0]     wr_burst;
    logic                   wr_rdy;
    logic                   wr_vld;
    logic [DATA_W-1:0]      wr_data;
    logic [N_RD-1:0]        rd_req;
    logic [N_RD-1:0]        rd_grant;
    logic [N_RD-1:0]        rd_en;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD-1:0]        rd_vld;
    logic [DATA_W-1:0]      rd_data;

    // Client side: the decoder and the display/scaler readers.
    modport master (
        output wr_req, wr_addr, wr_burst, wr_vld, wr_data,
        output rd_req, rd_en, rd_addr,
        input  wr_grant, wr_rdy, rd_grant, rd_vld, rd_data
    );

    // Memory side.
    modport slave (
        input  wr_req, wr_addr, wr_burst, wr_vld, wr_data,
        input  rd_req, rd_en, rd_addr,
        output wr_grant, wr_rdy, rd_grant, rd_vld, rd_data
    );
endinterface

// File: rtl/px_rr_arb.sv
// Round-robin picker: first requester at or after the pointer, wrapping around.
module px_rr_arb #(
    parameter int N_RD  = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_RD-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_RD-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan clients starting at the pointer; the first hit wins.
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_RD; off++) begin
            cand = (int'(ptr) + off) % N_RD;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/px_mem_mp.sv
// Pixel frame memory: one burst writer with priority, N_RD round-robin readers with a
// hold quantum, single-port synchronous RAM with a registered read port.
module px_mem_mp
    import px_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int N_RD       = 2,
    parameter int BURST_W    = 4,
    parameter int RD_QUANTUM = 64
) (
    input logic       clk,
    input logic       rst_n,
    px_mem_mp_if.slave bus
);

    localparam int IDX_W = px_clog2(N_RD);
    localparam int Q_W   = px_clog2(RD_QUANTUM);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RD - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(RD_QUANTUM - 1);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_RD_GNT   = RD_GNT;
    localparam logic [1:0] ST_WR_CMD   = WR_CMD;
    localparam logic [1:0] ST_WR_BURST = WR_BURST;

    logic [1:0]         state_reg, state_next;
    logic [ADDR_W-1:0]  waddr_reg, waddr_next;
    logic [BURST_W-1:0] remain_reg, remain_next;
    logic [IDX_W-1:0]   gnt_idx_reg, gnt_idx_next;
    logic [N_RD-1:0]    gnt_oh_reg, gnt_oh_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [Q_W-1:0]     quant_reg, quant_next;
    logic [N_RD-1:0]    rd_vld_reg;
    logic [DATA_W-1:0]  rd_data_reg;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  rd_addr_arr [N_RD];
    logic [N_RD-1:0]    arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               in_rd;
    logic               rd_fire;
    logic               req_held;
    logic               others_pend;
    logic               wr_xfer;
    logic [IDX_W-1:0]   ptr_after;

    // Split the packed read-address bus into one address per client.
    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd_addr
            assign rd_addr_arr[gi] = bus.rd_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    px_rr_arb #(
        .N_RD  (N_RD),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (bus.rd_req),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign in_rd       = (state_reg == ST_RD_GNT);
    assign rd_fire     = in_rd && |(bus.rd_en & gnt_oh_reg);
    assign req_held    = |(bus.rd_req & gnt_oh_reg);
    assign others_pend = bus.wr_req || |(bus.rd_req & ~gnt_oh_reg);
    assign wr_xfer     = (state_reg == ST_WR_BURST) && bus.wr_vld;
    assign ptr_after   = (gnt_idx_reg == IDX_LAST) ? '0 : gnt_idx_reg + IDX_W'(1);

    assign bus.wr_grant = (state_reg == ST_WR_CMD) || (state_reg == ST_WR_BURST);
    assign bus.wr_rdy   = (state_reg == ST_WR_BURST);
    assign bus.rd_grant = in_rd ? gnt_oh_reg : '0;
    assign bus.rd_vld   = rd_vld_reg;
    assign bus.rd_data  = rd_data_reg;

    // Next-state logic: write priority, read grant with forced release after the quantum.
    always_comb begin
        state_next   = state_reg;
        waddr_next   = waddr_reg;
        remain_next  = remain_reg;
        gnt_idx_next = gnt_idx_reg;
        gnt_oh_next  = gnt_oh_reg;
        rr_ptr_next  = rr_ptr_reg;
        quant_next   = quant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    state_next = ST_WR_CMD;
                end else if (arb_any) begin
                    state_next   = ST_RD_GNT;
                    gnt_idx_next = arb_idx;
                    gnt_oh_next  = arb_grant;
                    quant_next   = '0;
                end
            end
            ST_WR_CMD: begin
                waddr_next  = bus.wr_addr;
                remain_next = bus.wr_burst;
                state_next  = ST_WR_BURST;
            end
            ST_WR_BURST: begin
                if (bus.wr_vld) begin
                    waddr_next  = waddr_reg + ADDR_W'(1);
                    remain_next = remain_reg - BURST_W'(1);
                    if (remain_reg == '0) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RD_GNT: begin
                if (!req_held || (others_pend && quant_reg == Q_LAST)) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = ptr_after;
                    quant_next  = '0;
                end else if (others_pend) begin
                    quant_next = quant_reg + Q_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            waddr_reg   <= '0;
            remain_reg  <= '0;
            gnt_idx_reg <= '0;
            gnt_oh_reg  <= '0;
            rr_ptr_reg  <= '0;
            quant_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            waddr_reg   <= waddr_next;
            remain_reg  <= remain_next;
            gnt_idx_reg <= gnt_idx_next;
            gnt_oh_reg  <= gnt_oh_next;
            rr_ptr_reg  <= rr_ptr_next;
            quant_reg   <= quant_next;
        end
    end

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_xfer) begin
            mem[waddr_reg] <= bus.wr_data;
        end
    end

    // Registered read: data and the owner's valid pulse appear one cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
            rd_vld_reg  <= '0;
        end else begin
            rd_vld_reg <= rd_fire ? gnt_oh_reg : '0;
            if (rd_fire) begin
                rd_data_reg <= mem[rd_addr_arr[gnt_idx_reg]];
            end
        end
    end

endmodule

// File: tb/tb_px_mem_mp.sv
// Directed plus randomized bench for px_mem_mp against an array-based memory model.
module tb_px_mem_mp;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 20;
    localparam int N_RD       = 2;
    localparam int BURST_W    = 4;
    localparam int RD_QUANTUM = 64;
    localparam int AMASK      = (1 << ADDR_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    px_mem_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .BURST_W(BURST_W)) bus ();

    px_mem_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .BURST_W(BURST_W), .RD_QUANTUM(RD_QUANTUM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] model [int];
    int          written_q [$];
    logic [15:0] wdata_q [$];
    int          raddr_q [$];
    bit          vld_pat [$];
    int          rr_ptr_m = 0;

    function automatic int first_req(input logic [N_RD-1:0] req, input int ptr);
        for (int off = 0; off < N_RD; off++) begin
            int c;
            c = (ptr + off) % N_RD;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_burst = '0;
        bus.wr_vld   = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = '0;
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_grant"}, 32'(bus.wr_grant), 0);
        chk({tag, "_wr_rdy"},   32'(bus.wr_rdy),   0);
        chk({tag, "_rd_grant"}, 32'(bus.rd_grant), 0);
        chk({tag, "_rd_vld"},   32'(bus.rd_vld),   0);
        chk({tag, "_rd_data"},  32'(bus.rd_data),  0);
    endtask

    // Burst write of wdata_q; beat pattern from vld_pat, else random gaps or none.
    // abort_after >= 0 returns right after that many beats have been transferred.
    task automatic write_burst(input int addr, input int len, input bit rand_gaps, input int abort_after);
        int beats, cyc;
        bit vld;
        bus.wr_req   = 1'b1;
        bus.wr_addr  = ADDR_W'(addr);
        bus.wr_burst = BURST_W'(len - 1);
        bus.wr_vld   = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.wr_grant && cyc < 50);
        chk("wr_cmd_grant",  32'(bus.wr_grant), 1);
        chk("wr_cmd_rdy",    32'(bus.wr_rdy),   0);
        chk("wr_cmd_rdgnt",  32'(bus.rd_grant), 0);
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("wr_burst_rdy", 32'(bus.wr_rdy), 1);
        bus.wr_addr  = ADDR_W'($urandom);
        bus.wr_burst = BURST_W'($urandom);
        beats = 0;
        cyc   = 0;
        while (beats < len && beats != abort_after && cyc < 200) begin
            if (vld_pat.size() > 0) vld = vld_pat.pop_front();
            else                    vld = rand_gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            bus.wr_vld  = vld;
            bus.wr_data = vld ? wdata_q[beats] : 16'($urandom);
            if (vld) begin
                model[(addr + beats) & AMASK] = wdata_q[beats];
                written_q.push_back((addr + beats) & AMASK);
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (beats < len) chk("wr_rdy_hold", 32'(bus.wr_rdy), 1);
        end
        bus.wr_vld = 1'b0;
        vld_pat.delete();
        if (beats != abort_after) begin
            chk("wr_done_grant", 32'(bus.wr_grant), 0);
            chk("wr_done_rdy",   32'(bus.wr_rdy),   0);
        end
        $display("write  addr=%05h len=%0d beats=%0d cycles=%0d", addr, len, beats, cyc);
    endtask

    // Streaming read by client c of every address in raddr_q, then release.
    task automatic read_session(input int c);
        int cyc, n;
        logic [N_RD-1:0] oh;
        oh = N_RD'(1 << c);
        n  = raddr_q.size();
        bus.rd_req[c] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.rd_grant != oh && cyc < 100);
        chk("rd_grant", 32'(bus.rd_grant), 32'(oh));
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                chk("rd_vld",  32'(bus.rd_vld),  32'(oh));
                chk("rd_data", 32'(bus.rd_data), 32'(model[raddr_q[i-1]]));
            end
            if (i < n) begin
                bus.rd_en[c] = 1'b1;
                bus.rd_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(raddr_q[i]);
            end else begin
                bus.rd_en[c]  = 1'b0;
                bus.rd_req[c] = 1'b0;
            end
            @(negedge clk);
        end
        chk("rd_release_grant", 32'(bus.rd_grant), 0);
        chk("rd_release_vld",   32'(bus.rd_vld),   0);
        rr_ptr_m = (c + 1) % N_RD;
        $display("read   client=%0d words=%0d", c, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        rr_ptr_m = 0;
        @(negedge clk);
        chk("post_reset_grant", 32'(bus.wr_grant), 0);
    endtask

    initial begin
        int exp_c, cnt, base, len;
        bit novld_ok;
        idle_inputs();
        do_reset();

        // Basic burst and streaming readback.
        wdata_q = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
        write_burst(32'h10, 4, 1'b0, -1);
        raddr_q = '{32'h10, 32'h11, 32'h12, 32'h13};
        read_session(0);

        // Gapped burst next to a sentinel word: exactly four words must land.
        wdata_q = '{16'h5A5A};
        write_burst(32'h104, 1, 1'b0, -1);
        wdata_q = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        vld_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        write_burst(32'h100, 4, 1'b0, -1);
        raddr_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
        read_session(1);

        // Address wrap at the top of memory.
        wdata_q = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        write_burst(32'hFFFFE, 4, 1'b0, -1);
        raddr_q = '{32'hFFFFE, 32'hFFFFF, 32'h0, 32'h1};
        read_session(0);

        // Random read by client 1 to bring the pointer back to 0.
        raddr_q.delete();
        repeat (3) raddr_q.push_back(written_q[$urandom_range(0, written_q.size() - 1)]);
        read_session(1);

        // Two readers contend: quantum-bounded hold, then the other reader.
        exp_c = first_req(2'b11, rr_ptr_m);
        bus.rd_req = 2'b11;
        bus.rd_en  = 2'b10;
        bus.rd_addr[1*ADDR_W +: ADDR_W] = ADDR_W'(32'h10);
        @(negedge clk);
        chk("arb_first", 32'(bus.rd_grant), 32'(1 << exp_c));
        cnt = 0;
        novld_ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (bus.rd_grant != 2'b01) break;
            cnt++;
            if (bus.rd_vld != 2'b00) novld_ok = 1'b0;
            @(negedge clk);
        end
        chk("quantum_len", 32'(cnt), RD_QUANTUM);
        chk("no_vld_ungranted", 32'(novld_ok), 1);
        chk("forced_release_idle", 32'(bus.rd_grant), 0);
        chk("forced_release_vld", 32'(bus.rd_vld), 0);
        rr_ptr_m = (exp_c + 1) % N_RD;
        exp_c = first_req(2'b11, rr_ptr_m);
        @(negedge clk);
        chk("arb_second", 32'(bus.rd_grant), 32'(1 << exp_c));
        @(negedge clk);
        chk("arb_second_vld",  32'(bus.rd_vld),  32'(2'b10));
        chk("arb_second_data", 32'(bus.rd_data), 32'(model[32'h10]));
        bus.rd_req = '0;
        bus.rd_en  = '0;
        @(negedge clk);
        chk("arb_done_grant", 32'(bus.rd_grant), 0);
        rr_ptr_m = (exp_c + 1) % N_RD;
        $display("arb    quantum_cycles=%0d second_client=%0d", cnt, exp_c);

        // Simultaneous write and read request: write is served first.
        base = int'($urandom_range(0, AMASK));
        wdata_q = '{16'($urandom), 16'($urandom)};
        bus.rd_req[0] = 1'b1;
        write_burst(base, 2, 1'b0, -1);
        raddr_q = '{base, (base + 1) & AMASK};
        read_session(0);

        // Randomized traffic.
        for (int t = 0; t < 8; t++) begin
            base = int'($urandom_range(0, AMASK));
            len  = int'($urandom_range(1, 1 << BURST_W));
            wdata_q.delete();
            for (int b = 0; b < len; b++) wdata_q.push_back(16'($urandom));
            write_burst(base, len, 1'b1, -1);
            raddr_q.delete();
            repeat ($urandom_range(1, 6)) raddr_q.push_back(written_q[$urandom_range(0, written_q.size() - 1)]);
            read_session(int'($urandom_range(0, N_RD - 1)));
        end

        // Asynchronous reset in the middle of a burst.
        wdata_q = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        write_burst(32'h2000, 4, 1'b0, 2);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        rr_ptr_m = 0;
        @(negedge clk);
        chk("after_rst_grant", 32'(bus.wr_grant), 0);
        raddr_q = '{32'h2000, 32'h2001};
        read_session(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

endmodule
